// File: rtl/mesi_ccu_pkg.sv
// -----------------------------------------------------------------------------
// mesi_pkg
// Shared types and helpers for the MESI cache coherence unit (mesi_ccu).
//   mesi_t          : MESI line state (M=00, E=01, S=10, I=11)
//   ccu_state_t     : coherence unit FSM states
//   mesi_resolve_t  : {requester state, snooped-core state}
//   mesi_resolve()  : maps (is_write, snoop_hit) to the new states
// -----------------------------------------------------------------------------
package mesi_pkg;

  typedef enum logic [1:0] {
    MESI_M = 2'b00,
    MESI_E = 2'b01,
    MESI_S = 2'b10,
    MESI_I = 2'b11
  } mesi_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_MEM_RD,
    ST_RESPOND
  } ccu_state_t;

  typedef struct packed {
    mesi_t req_state;
    mesi_t snp_state;
  } mesi_resolve_t;

  // A write always takes ownership (M) and invalidates the other copy; a read
  // shares the line when the other core has it, otherwise gets it exclusive.
  // The snooped state is only meaningful on a hit.
  function automatic mesi_resolve_t mesi_resolve(input logic is_write,
                                                 input logic snoop_hit);
    mesi_resolve_t r;
    if (is_write) begin
      r.req_state = MESI_M;
      r.snp_state = MESI_I;
    end else if (snoop_hit) begin
      r.req_state = MESI_S;
      r.snp_state = MESI_S;
    end else begin
      r.req_state = MESI_E;
      r.snp_state = MESI_I;
    end
    return r;
  endfunction

endpackage

// File: rtl/mesi_ccu_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. Grant is combinational from req; on a tie the
// core not granted last time wins. The pointer advances only when update is
// strobed with a non-zero grant. After reset core 0 wins the first tie.
//   clk, rst      : clock, synchronous active-high reset
//   req[1:0]      : request per core
//   update        : accept the current grant (advance the pointer)
//   grant[1:0]    : one-hot grant
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_q;  // core that was granted most recently

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst)                    last_q <= 1'b1;
    else if (update && |grant)  last_q <= grant[1];
  end

endmodule

// File: rtl/mesi_ccu.sv
// -----------------------------------------------------------------------------
// mesi_ccu
// Coherence unit between two L1 controllers and next-level memory. Arbitrates
// a miss, snoops the other L1, sources data from the snoop hit or memory, and
// returns the word with the requester's new MESI state; the snooped core is
// told its new state on a hit.
// Optional: define MESI_CCU_SNOOP_TIMEOUT_EN to treat a snoop that does not
// complete within SNOOP_TIMEOUT cycles as a miss.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req, wr, addr0, addr1      : per-core miss request, type, address
//   ccu_ready, data_out, upd_state : response pulse, word, requester state
//   bs_req, snoop_addr         : snoop request (level) and address
//   snoop_done, bs_resp, snoop_data0/1 : snoop completion, hit, data
//   snoop_upd_state, snoop_upd_valid   : new state pulse to snooped core
//   mem_rd, mem_addr, mem_rdata, mem_valid : memory read handshake
// -----------------------------------------------------------------------------
module mesi_ccu
  import mesi_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int SNOOP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        wr,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        ccu_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        upd_state,
  output logic [1:0]        bs_req,
  output logic [ADDR_W-1:0] snoop_addr,
  input  logic [1:0]        snoop_done,
  input  logic [1:0]        bs_resp,
  input  logic [DATA_W-1:0] snoop_data0,
  input  logic [DATA_W-1:0] snoop_data1,
  output logic [1:0]        snoop_upd_state,
  output logic [1:0]        snoop_upd_valid,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
);

  if (SNOOP_TIMEOUT < 1) begin : g_bad_timeout
    $fatal(1, "SNOOP_TIMEOUT must be at least 1");
  end

  ccu_state_t    state_q, state_d;
  logic          gnt_q;      // granted core
  logic          wr_q;       // granted request is a write miss
  logic          hit_q;      // snoop found a valid copy
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]    grant;
  logic          grant_en;
  logic          snp;        // the core being snooped (the other one)
  mesi_resolve_t res;

  assign snp      = ~gnt_q;
  assign grant_en = (state_q == ST_IDLE) && (|req);
  assign res      = mesi_resolve(wr_q, hit_q);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (grant_en),
    .grant  (grant)
  );

`ifdef MESI_CCU_SNOOP_TIMEOUT_EN
  localparam int TO_W = $clog2(SNOOP_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_expired;

  // Counts cycles spent in SNOOP; restarts on every entry.
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_SNOOP) to_cnt_q <= '0;
    else                            to_cnt_q <= to_cnt_q + 1'b1;
  end
  assign to_expired = (to_cnt_q == TO_W'(SNOOP_TIMEOUT - 1));
`else
  logic to_expired;
  assign to_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|req) state_d = ST_SNOOP;
      ST_SNOOP: begin
        if (snoop_done[snp]) state_d = bs_resp[snp] ? ST_RESPOND : ST_MEM_RD;
        else if (to_expired) state_d = ST_MEM_RD;
      end
      ST_MEM_RD:  if (mem_valid) state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Transaction context: captured at grant, filled in by snoop or memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q  <= 1'b0;
      wr_q   <= 1'b0;
      hit_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (|req) begin
          gnt_q  <= grant[1];
          wr_q   <= grant[1] ? wr[1] : wr[0];
          addr_q <= grant[1] ? addr1 : addr0;
          hit_q  <= 1'b0;
        end
        ST_SNOOP: if (snoop_done[snp] && bs_resp[snp]) begin
          hit_q  <= 1'b1;
          data_q <= snp ? snoop_data1 : snoop_data0;
        end
        ST_MEM_RD: if (mem_valid) data_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only, so reset forces them all low.
  always_comb begin
    ccu_ready       = '0;
    data_out        = '0;
    upd_state       = '0;
    bs_req          = '0;
    snoop_addr      = '0;
    snoop_upd_state = '0;
    snoop_upd_valid = '0;
    mem_rd          = 1'b0;
    mem_addr        = '0;
    case (state_q)
      ST_SNOOP: begin
        bs_req[snp] = 1'b1;
        snoop_addr  = addr_q;
      end
      ST_MEM_RD: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
      end
      ST_RESPOND: begin
        ccu_ready[gnt_q] = 1'b1;
        data_out         = data_q;
        upd_state        = res.req_state;
        if (hit_q) begin
          snoop_upd_valid[snp] = 1'b1;
          snoop_upd_state      = res.snp_state;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mesi_ccu.sv
// -----------------------------------------------------------------------------
// tb_mesi_ccu
// Self-checking bench for mesi_ccu. The main process plays both L1s and the
// memory; expected responses are pushed into a queue when requests are issued
// and a separate monitor pops and compares on every ccu_ready pulse.
// -----------------------------------------------------------------------------
module tb_mesi_ccu;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, wr;
  logic [AW-1:0] addr0, addr1;
  logic [1:0]    ccu_ready;
  logic [DW-1:0] data_out;
  logic [1:0]    upd_state;
  logic [1:0]    bs_req;
  logic [AW-1:0] snoop_addr;
  logic [1:0]    snoop_done, bs_resp;
  logic [DW-1:0] snoop_data0, snoop_data1;
  logic [1:0]    snoop_upd_state, snoop_upd_valid;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;

  always #5 clk = ~clk;

  mesi_ccu #(.ADDR_W(AW), .DATA_W(DW), .SNOOP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr0(addr0), .addr1(addr1),
    .ccu_ready(ccu_ready), .data_out(data_out), .upd_state(upd_state),
    .bs_req(bs_req), .snoop_addr(snoop_addr), .snoop_done(snoop_done),
    .bs_resp(bs_resp), .snoop_data0(snoop_data0), .snoop_data1(snoop_data1),
    .snoop_upd_state(snoop_upd_state), .snoop_upd_valid(snoop_upd_valid),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  typedef struct {
    int          core;
    logic [31:0] data;
    logic [1:0]  state;
    logic [1:0]  snp_valid;
    logic [1:0]  snp_state;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_served;  // reference model of the round-robin history

  // What each core's current request should see from the environment.
  logic        cfg_wr[2];
  logic        cfg_hit[2];
  logic [31:0] cfg_addr[2], cfg_sdata[2], cfg_mdata[2];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Expected outcome from the coherence rules: writes end in M and invalidate
  // the other copy; reads share on a hit (S/S) or become exclusive on a miss.
  function automatic exp_t model(input int core);
    exp_t e;
    e.core = core;
    e.data = cfg_hit[core] ? cfg_sdata[core] : cfg_mdata[core];
    if (cfg_wr[core])       e.state = 2'b00;
    else if (cfg_hit[core]) e.state = 2'b10;
    else                    e.state = 2'b01;
    e.snp_valid = cfg_hit[core] ? ((core == 0) ? 2'b10 : 2'b01) : 2'b00;
    e.snp_state = !cfg_hit[core] ? 2'b00 : (cfg_wr[core] ? 2'b11 : 2'b10);
    return e;
  endfunction

  task automatic set_cfg(input int c, input logic w, input logic [31:0] a,
                         input logic hit, input logic [31:0] sd,
                         input logic [31:0] md);
    cfg_wr[c] = w; cfg_addr[c] = a; cfg_hit[c] = hit;
    cfg_sdata[c] = sd; cfg_mdata[c] = md;
  endtask

  // Raise requests (DUT idle) and predict service order.
  task automatic issue(input logic [1:0] which);
    int first, second;
    if (which == 2'b11) begin
      first  = (last_served == 0) ? 1 : 0;
      second = 1 - first;
      exp_q.push_back(model(first));
      exp_q.push_back(model(second));
      last_served = second;
    end else begin
      first = which[1] ? 1 : 0;
      exp_q.push_back(model(first));
      last_served = first;
    end
    for (int c = 0; c < 2; c++) begin
      if (which[c]) begin
        wr[c]  = cfg_wr[c];
        req[c] = 1'b1;
      end
    end
    addr0 = cfg_addr[0];
    addr1 = cfg_addr[1];
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctrl"}, {ccu_ready, upd_state, bs_req, snoop_upd_state,
                           snoop_upd_valid, mem_rd}, 0);
    check({tag, "_data_out"},   data_out, 0);
    check({tag, "_snoop_addr"}, snoop_addr, 0);
    check({tag, "_mem_addr"},   mem_addr, 0);
  endtask

  task automatic wait_bs_req(output logic ok);
    int n = 0;
    while (bs_req == 2'b00 && n < 100) begin @(negedge clk); n++; end
    ok = (bs_req != 2'b00);
    if (!ok) check("bs_req_timeout", 0, 1);
  endtask

  // Serve one transaction as the two L1s plus memory, with random latencies
  // and stray handshakes from the protocol step that is not current.
  task automatic serve_one();
    int   s, g, n, d;
    logic ok;
    wait_bs_req(ok);
    if (!ok) return;
    s = bs_req[1] ? 1 : 0;
    g = 1 - s;
    check("bs_req_onehot", $countones(bs_req), 1);
    check("snoop_addr", snoop_addr, cfg_addr[g]);
    d = $urandom_range(0, 3);
    repeat (d) begin
      mem_valid = 1'($urandom_range(0, 1));
      mem_rdata = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
      @(negedge clk);
      check("bs_req_held", bs_req[s], 1);
    end
    snoop_done[s] = 1'b1;
    bs_resp[s]    = cfg_hit[g];
    if (s == 0) snoop_data0 = cfg_sdata[g]; else snoop_data1 = cfg_sdata[g];
    mem_valid     = 1'($urandom_range(0, 1));  // coincident, must be ignored
    mem_rdata     = 32'hBAD1_BAD1;
    @(negedge clk);
    snoop_done = '0; bs_resp = '0; mem_valid = 1'b0;
    check("bs_req_released", bs_req, 0);
    if (cfg_hit[g]) begin
      check("mem_rd_on_hit", mem_rd, 0);
    end else begin
      n = 0;
      while (!mem_rd && n < 20) begin @(negedge clk); n++; end
      check("mem_rd_seen", mem_rd, 1);
      check("mem_addr", mem_addr, cfg_addr[g]);
      d = $urandom_range(0, 3);
      repeat (d) begin
        snoop_done[s] = 1'($urandom_range(0, 1));  // stray, must be ignored
        bs_resp[s]    = 1'b1;
        snoop_data0   = 32'hBAD2_BAD2;
        snoop_data1   = 32'hBAD3_BAD3;
        @(negedge clk);
      end
      snoop_done = '0; bs_resp = '0;
      mem_valid = 1'b1;
      mem_rdata = cfg_mdata[g];
      @(negedge clk);
      mem_valid = 1'b0;
    end
    n = 0;
    while (ccu_ready[g] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("ccu_ready_seen", ccu_ready[g], 1);
    req[g] = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (ccu_ready != 2'b00) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ccu_ready", ccu_ready, 0);
          end else begin
            e = exp_q.pop_front();
            check("ready_core", ccu_ready, (e.core == 1) ? 2'b10 : 2'b01);
            check("data_out", data_out, e.data);
            check("upd_state", upd_state, e.state);
            check("snoop_upd_valid", snoop_upd_valid, e.snp_valid);
            if (e.snp_valid != 2'b00)
              check("snoop_upd_state", snoop_upd_state, e.snp_state);
          end
        end else if (snoop_upd_valid != 2'b00) begin
          check("stray_snoop_upd_valid", snoop_upd_valid, 0);
        end
      end
    end
  end

  initial begin
    logic ok;
    int   n, mode;
    rst = 1'b1; req = '0; wr = '0; addr0 = '0; addr1 = '0;
    snoop_done = '0; bs_resp = '0; snoop_data0 = '0; snoop_data1 = '0;
    mem_rdata = '0; mem_valid = 1'b0;
    last_served = 1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    // Simultaneous requests, twice: core 0 then core 1 each time.
    set_cfg(0, 1'b0, 32'h0000_2000, 1'b0, 32'h0, 32'hAAAA_0001);
    set_cfg(1, 1'b1, 32'h0000_3000, 1'b1, 32'hBBBB_0002, 32'h0);
    issue(2'b11);
    serve_one(); serve_one();
    set_cfg(0, 1'b1, 32'h0000_2040, 1'b0, 32'h0, 32'hAAAA_0003);
    set_cfg(1, 1'b0, 32'h0000_3040, 1'b0, 32'h0, 32'hBBBB_0004);
    issue(2'b11);
    serve_one(); serve_one();

    // Core 0 read miss served from memory.
    set_cfg(0, 1'b0, 32'h0000_1040, 1'b0, 32'h0, 32'hDEAD_BEEF);
    issue(2'b01); serve_one();
    // Core 1 read, core 0 hit.
    set_cfg(1, 1'b0, 32'h0000_5080, 1'b1, 32'h1234_5678, 32'h0);
    issue(2'b10); serve_one();
    // Core 0 write, core 1 hit.
    set_cfg(0, 1'b1, 32'h0000_60C0, 1'b1, 32'hCAFE_F00D, 32'h0);
    issue(2'b01); serve_one();

    // Reset while waiting on memory.
    set_cfg(0, 1'b0, 32'h0000_7000, 1'b0, 32'h0, 32'h5555_AAAA);
    issue(2'b01);
    wait_bs_req(ok);
    if (ok) begin
      snoop_done[1] = 1'b1; bs_resp[1] = 1'b0;
      @(negedge clk);
      snoop_done = '0;
      n = 0;
      while (!mem_rd && n < 20) begin @(negedge clk); n++; end
      check("rst_test_mem_rd", mem_rd, 1);
    end
    rst = 1'b1; req = '0;
    @(negedge clk);
    check_quiet("mid_reset");
    exp_q.delete();
    last_served = 1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("after_reset");
    set_cfg(0, 1'b1, 32'h0000_7100, 1'b0, 32'h0, 32'h0F0F_0F0F);
    set_cfg(1, 1'b0, 32'h0000_7200, 1'b1, 32'hF0F0_F0F0, 32'h0);
    issue(2'b11);
    serve_one(); serve_one();

`ifdef MESI_CCU_SNOOP_TIMEOUT_EN
    // Snoop never completes: fall back to memory after the timeout.
    set_cfg(0, 1'b0, 32'h0000_8000, 1'b1, 32'h0, 32'h7777_8888);
    cfg_hit[0] = 1'b0;  // timed-out snoop behaves as a miss
    issue(2'b01);
    wait_bs_req(ok);
    n = 0;
    while (bs_req != 2'b00 && n < 40) begin n++; @(negedge clk); end
    check("timeout_cycles", n, 16);
    check("mem_rd_after_timeout", mem_rd, 1);
    mem_valid = 1'b1; mem_rdata = 32'h7777_8888;
    @(negedge clk);
    mem_valid = 1'b0;
    check("timeout_ready", ccu_ready[0], 1);
    req[0] = 1'b0;
`endif

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < 2; c++)
        set_cfg(c, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                $urandom, $urandom);
      mode = $urandom_range(0, 2);
      if (mode == 2) begin
        issue(2'b11); serve_one(); serve_one();
      end else begin
        issue(mode == 0 ? 2'b01 : 2'b10); serve_one();
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesi_ccu.md
Name: mesi_ccu

Overview:
- Cache Coherence Unit sitting directly downstream of the two L1 cache controllers (core 0, core 1).
- Accepts a miss request from one L1 and snoops the other L1 for the line.
- Sources the data word from the snooped cache on a snoop hit; otherwise reads it from the next-level memory.
- Returns the data word plus the requester's new MESI state, and sends the snooped core its updated MESI state.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width (one word per transfer).
- SNOOP_TIMEOUT, 16, cycles to wait for snoop completion (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-core miss request; bit i = core i. Held until that core's ccu_ready.
- wr  in  2  per-core request type: 1 = write miss, 0 = read miss. Valid with req.
- addr0 / addr1  in  ADDR_W  per-core request address.
- ccu_ready  out  2  one-cycle pulse to the requester: data_out and upd_state are valid.
- data_out  out  DATA_W  data word returned to the requester.
- upd_state  out  2  MESI state for the requester's line.
- bs_req  out  2  snoop request to core i (level, held until snoop_done).
- snoop_addr  out  ADDR_W  address being snooped.
- snoop_done  in  2  core i finished its snoop lookup.
- bs_resp  in  2  core i holds a valid copy; sampled with snoop_done.
- snoop_data0 / snoop_data1  in  DATA_W  snooped data word; valid with bs_resp.
- snoop_upd_state  out  2  new MESI state for the snooped core's line; valid while snoop_upd_valid.
- snoop_upd_valid  out  2  one-cycle pulse to the snooped core.
- mem_rd  out  1  memory read request, held until mem_valid.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  memory data.
- mem_valid  in  1  memory data valid; single-cycle pulse.

Behaviour:
- MESI encoding: M=00, E=01, S=10, I=11.
- Reset: every output is 0 and the FSM is in IDLE. Round-robin pointer is set so core 0 wins the first tie.
- Reset asserted mid-operation: aborts the transaction. The next edge gives IDLE and all outputs 0. No partial ccu_ready is issued.
- FSM states: IDLE, SNOOP, MEM_RD, RESPOND.

IDLE:
- If any req bit is set, arbitrate with a 2-way round-robin. On a tie, the core not granted last time wins.
- Latch grant g, the type (wr[g]) and addr_g. Go to SNOOP.
- A request arriving while busy waits. req is never dropped.

SNOOP:
- bs_req[~g] = 1 and snoop_addr = latched address.
- On snoop_done[~g], clear bs_req.
  - bs_resp = 1: latch snoop_data, go to RESPOND.
  - bs_resp = 0: go to MEM_RD.

MEM_RD:
- mem_rd = 1 and mem_addr = latched address.
- On mem_valid, latch mem_rdata and go to RESPOND.

RESPOND (exactly one cycle, then IDLE):
- ccu_ready[g] = 1 and data_out = latched word.
- upd_state by case:
  - read + snoop hit: S; snooped core gets S.
  - read + miss: E.
  - write + snoop hit: M; snooped core gets I.
  - write + miss: M.
- snoop_upd_valid[~g] pulses in this same cycle, only on a snoop hit.

Timing and boundary rules:
- Minimum latency from req to ccu_ready is 3 cycles: IDLE -> SNOOP (snoop_done in the first SNOOP cycle) -> RESPOND.
- snoop_done and mem_valid arriving together: only the one relevant to the current state is honoured.
- The requester dropping req early is a protocol violation. The transaction completes anyway.
- The round-robin pointer updates only on a grant.

Optional Feature:
- Macro: MESI_CCU_SNOOP_TIMEOUT_EN.
- Defined: a counter starts on entry to SNOOP. After SNOOP_TIMEOUT cycles without snoop_done, treat the snoop as a miss: drop bs_req and go to MEM_RD.
- Undefined: SNOOP waits indefinitely and no counter is synthesised.

Decomposition:
- Package mesi_pkg holds:
  - mesi_t;
  - ccu_state_t;
  - a MESI-resolve function: (is_write, snoop_hit) -> {requester state, snooped state}.
- Sub-module rr_arbiter2: req[1:0] in; grant[1:0] out; an update strobe advances the pointer.

Test Plan:
- Core 0 read of 0x0000_1040; core 1 snoop_done with bs_resp = 0; mem_valid with 0xDEAD_BEEF -> ccu_ready[0] with data 0xDEAD_BEEF and upd_state E; no snoop_upd_valid.
- Core 1 read; core 0 bs_resp = 1 with 0x1234_5678 -> core 1 gets 0x1234_5678 and state S; snoop_upd_valid[0] with state S; mem_rd never asserted.
- Core 0 write miss; core 1 hit -> upd_state M; snoop_upd_state I to core 1.
- Both req set in the same cycle, twice back-to-back -> grants go core 0 then core 1; each gets exactly one ccu_ready.
- rst asserted during MEM_RD -> next cycle all outputs 0; no ccu_ready; a fresh request afterwards is served normally.
- With MESI_CCU_SNOOP_TIMEOUT_EN defined and snoop_done withheld -> bs_req drops after 16 cycles; mem_rd asserted the next cycle.
